// File: rtl/bank_read_streamer_if.sv
// Burst request, bank read port and output stream of bank_read_streamer.
// Optional stall_cnt member exists only when BANK_RD_STALL_CNT_EN is defined.
interface bank_read_streamer_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7,
   parameter int LEN_W  = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [LEN_W-1:0]  req_len;
   logic              bank_cs;
   logic [ADDR_W-1:0] bank_addr;
   logic [DATA_W-1:0] bank_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              done;
`ifdef BANK_RD_STALL_CNT_EN
   logic [15:0]       stall_cnt;

   // master: the streamer itself; slave: requester, bank and sink around it
   modport master (
      input  req_valid, req_addr, req_len, bank_rdata, out_ready,
      output req_ready, bank_cs, bank_addr, out_valid, out_data, out_last, busy, done, stall_cnt
   );
   modport slave (
      output req_valid, req_addr, req_len, bank_rdata, out_ready,
      input  req_ready, bank_cs, bank_addr, out_valid, out_data, out_last, busy, done, stall_cnt
   );
`else
   modport master (
      input  req_valid, req_addr, req_len, bank_rdata, out_ready,
      output req_ready, bank_cs, bank_addr, out_valid, out_data, out_last, busy, done
   );
   modport slave (
      output req_valid, req_addr, req_len, bank_rdata, out_ready,
      input  req_ready, bank_cs, bank_addr, out_valid, out_data, out_last, busy, done
   );
`endif
endinterface

// File: rtl/bank_read_streamer.sv
// Burst reader for the SRAM bank: one read per cycle, 2-entry skid FIFO onto a valid/ready stream.
// Define BANK_RD_STALL_CNT_EN to add the saturating stall_cnt output.
module bank_read_streamer #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 7,
   parameter int LEN_W  = 8
) (
   input logic                  vsi_clk,
   input logic                  vsi_reset_n,
   bank_read_streamer_if.master bus
);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
   state_t state, stateNext;

   logic [ADDR_W-1:0] curAddr, bankAddr;
   logic [LEN_W-1:0]  remaining, lenClamped;
   // [0]: read presented to the bank this cycle, [1]: its data is on bank_rdata
   logic [1:0]        vldPipe, lastPipe;
   logic [DATA_W-1:0] fifoData [2];
   logic [1:0]        fifoLast;
   logic              wrPtr, rdPtr;
   logic [1:0]        fifoCount, fifoNext;
   logic              doneR;
   logic              accept, issue, reqReady, headValid, outValid, outLast, xfer, push, pop;

   assign lenClamped = (bus.req_len > MAX_LEN) ? MAX_LEN : bus.req_len;
   assign accept     = bus.req_valid && reqReady;

   // Head of the FIFO, or the returning bank word passed straight through when the FIFO is empty
   assign headValid = (fifoCount != 2'd0);
   assign outValid  = headValid || vldPipe[1];
   assign outLast   = headValid ? fifoLast[rdPtr] : (vldPipe[1] && lastPipe[1]);
   assign xfer      = outValid && bus.out_ready;
   assign pop       = headValid && bus.out_ready;
   assign push      = vldPipe[1] && !(!headValid && bus.out_ready);
   assign fifoNext  = fifoCount + 2'(push) - 2'(pop);

   always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
      if (!vsi_reset_n) state <= IDLE;
      else              state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (accept && lenClamped != '0) stateNext = ISSUE;
         ISSUE:   if (issue && remaining == LEN_W'(1)) stateNext = DRAIN;
         DRAIN:   if (xfer && outLast) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // A new read needs a slot two cycles out: count what the FIFO holds after this cycle
   // plus the read already on the bank.
   always_comb begin
      reqReady = (state == IDLE);
      issue    = (state == ISSUE) && ((fifoNext + 2'(vldPipe[0])) < 2'd2);
   end

   always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
      if (!vsi_reset_n) begin
         curAddr   <= '0;
         bankAddr  <= '0;
         remaining <= '0;
         vldPipe   <= '0;
         lastPipe  <= '0;
         fifoLast  <= '0;
         wrPtr     <= 1'b0;
         rdPtr     <= 1'b0;
         fifoCount <= '0;
         doneR     <= 1'b0;
      end else begin
         vldPipe  <= {vldPipe[0], issue};
         lastPipe <= {lastPipe[0], issue && remaining == LEN_W'(1)};
         if (issue) bankAddr <= curAddr;
         if (accept && lenClamped != '0) begin
            curAddr   <= bus.req_addr;
            remaining <= lenClamped;
         end else if (issue) begin
            curAddr   <= curAddr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
         end
         if (push) begin
            fifoLast[wrPtr] <= lastPipe[1];
            wrPtr           <= ~wrPtr;
         end
         if (pop) rdPtr <= ~rdPtr;
         fifoCount <= fifoNext;
         doneR     <= xfer && outLast;
      end
   end

   always_ff @(posedge vsi_clk) begin
      if (push) fifoData[wrPtr] <= bus.bank_rdata;
   end

   assign bus.req_ready = reqReady;
   assign bus.busy      = !reqReady;
   assign bus.bank_cs   = vldPipe[0];
   assign bus.bank_addr = bankAddr;
   assign bus.out_valid = outValid;
   assign bus.out_last  = outLast;
   assign bus.out_data  = headValid ? fifoData[rdPtr] : (vldPipe[1] ? bus.bank_rdata : '0);
   assign bus.done      = doneR;

`ifdef BANK_RD_STALL_CNT_EN
   logic [15:0] stallCnt;
   always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
      if (!vsi_reset_n)                                          stallCnt <= '0;
      else if (accept)                                           stallCnt <= '0;
      else if (outValid && !bus.out_ready && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
   end
   assign bus.stall_cnt = stallCnt;
`endif
endmodule

// File: tb/tb_bank_read_streamer.sv
// Directed bench for bank_read_streamer: bank model with 1-cycle read latency, scripted sink.
module tb_bank_read_streamer;
   logic clk = 1'b0;
   logic rstN;
   int   cyc = 0;
   int   nTests = 0;
   int   nFail = 0;
   bit   bpMode = 1'b0;

   bank_read_streamer_if intf ();

   bank_read_streamer dut (
      .vsi_clk     (clk),
      .vsi_reset_n (rstN),
      .bus         (intf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] word(input logic [6:0] a);
      return {32'h1000 + 32'(a), 32'h2000 + 32'(a), 32'h3000 + 32'(a), 32'h4000 + 32'(a)};
   endfunction

   // Bank: data the cycle after chip select, garbage otherwise
   always @(posedge clk) begin
      if (intf.bank_cs) intf.bank_rdata <= word(intf.bank_addr);
      else              intf.bank_rdata <= {$urandom, $urandom, $urandom, $urandom};
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sink: always ready, or ready one cycle in three
   initial begin
      int k = 0;
      intf.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (bpMode) begin
            intf.out_ready = (k % 3 == 0);
            k++;
         end else intf.out_ready = 1'b1;
      end
   end

   logic [6:0]   issued [$];
   logic [127:0] rxData [$];
   bit           rxLast [$];
   int           rxCyc  [$];
   int           doneCyc [$];
   int           stallSeen;
   bit           prevStall = 1'b0;
   logic [127:0] prevData;

   always @(negedge clk) begin
      if (!rstN) prevStall = 1'b0;
      else begin
         if (intf.bank_cs) begin
            issued.push_back(intf.bank_addr);
            check("credit", 128'(issued.size() - rxData.size() <= 2), 128'(1));
         end
         if (prevStall) begin
            check("validHold", 128'(intf.out_valid), 128'(1));
            check("dataHold", intf.out_data, prevData);
         end
         prevStall = intf.out_valid && !intf.out_ready;
         prevData  = intf.out_data;
         if (prevStall) stallSeen++;
         if (intf.out_valid && intf.out_ready) begin
            rxData.push_back(intf.out_data);
            rxLast.push_back(intf.out_last);
            rxCyc.push_back(cyc);
         end
         if (intf.done) doneCyc.push_back(cyc);
      end
   end

   task automatic clearMon();
      issued.delete(); rxData.delete(); rxLast.delete(); rxCyc.delete(); doneCyc.delete();
      stallSeen = 0;
   endtask

   task automatic checkReset(input string tag);
      check({tag, ".bank_cs"},   128'(intf.bank_cs),   128'(0));
      check({tag, ".bank_addr"}, 128'(intf.bank_addr), 128'(0));
      check({tag, ".out_valid"}, 128'(intf.out_valid), 128'(0));
      check({tag, ".out_data"},  intf.out_data,        128'(0));
      check({tag, ".out_last"},  128'(intf.out_last),  128'(0));
      check({tag, ".busy"},      128'(intf.busy),      128'(0));
      check({tag, ".done"},      128'(intf.done),      128'(0));
      check({tag, ".req_ready"}, 128'(intf.req_ready), 128'(1));
`ifdef BANK_RD_STALL_CNT_EN
      check({tag, ".stall_cnt"}, 128'(intf.stall_cnt), 128'(0));
`endif
   endtask

   task automatic runBurst(input logic [6:0] a, input logic [7:0] len, input int n, input bit fullRate);
      int acc;
      int w;
      logic [6:0] ea;
      clearMon();
      @(posedge clk); #1;
      intf.req_valid = 1'b1; intf.req_addr = a; intf.req_len = len;
      acc = cyc;
      check("reqReady", 128'(intf.req_ready), 128'(1));
      @(posedge clk); #1;
      intf.req_valid = 1'b0;
      if (n == 0) begin
         check("len0.busy", 128'(intf.busy), 128'(0));
         repeat (8) @(posedge clk);
         #1;
         check("len0.reads", 128'(issued.size()), 128'(0));
         check("len0.done", 128'(doneCyc.size()), 128'(0));
         check("len0.reqReady", 128'(intf.req_ready), 128'(1));
         return;
      end
      check("busyAfterAccept", 128'(intf.busy), 128'(1));
      w = 0;
      while (doneCyc.size() == 0 && w < 1000) begin
         @(negedge clk); #1;
         w++;
      end
      check("doneTimeout", 128'(doneCyc.size() != 0), 128'(1));
      @(negedge clk); #1;
      check("nWords", 128'(rxData.size()), 128'(n));
      check("nReads", 128'(issued.size()), 128'(n));
      check("donePulses", 128'(doneCyc.size()), 128'(1));
      check("idleReqReady", 128'(intf.req_ready), 128'(1));
      check("idleBusy", 128'(intf.busy), 128'(0));
      for (int i = 0; i < n && i < issued.size(); i++) begin
         ea = a + 7'(i);
         check($sformatf("addr[%0d]", i), 128'(issued[i]), 128'(ea));
      end
      for (int i = 0; i < n && i < rxData.size(); i++) begin
         ea = a + 7'(i);
         check($sformatf("data[%0d]", i), rxData[i], word(ea));
         check($sformatf("last[%0d]", i), 128'(rxLast[i]), 128'(i == n - 1));
      end
      if (rxCyc.size() == n && doneCyc.size() > 0)
         check("doneLat", 128'(doneCyc[0]), 128'(rxCyc[n-1] + 1));
      if (fullRate && rxCyc.size() == n && doneCyc.size() > 0) begin
         check("firstCyc", 128'(rxCyc[0]), 128'(acc + 3));
         check("lastCyc", 128'(rxCyc[n-1]), 128'(acc + n + 2));
         check("doneCyc", 128'(doneCyc[0]), 128'(acc + n + 3));
      end
`ifdef BANK_RD_STALL_CNT_EN
      check("stall_cnt", 128'(intf.stall_cnt), 128'(stallSeen));
`endif
   endtask

   initial begin
      int w;
      rstN = 1'b0;
      intf.req_valid = 1'b0; intf.req_addr = '0; intf.req_len = '0;
      repeat (3) @(negedge clk);
      #1 checkReset("reset");
      @(negedge clk) rstN = 1'b1;

      runBurst(7'h10, 8'd4, 4, 1'b1);
      runBurst(7'h7E, 8'd4, 4, 1'b1);
      bpMode = 1'b1;
      runBurst(7'h30, 8'd8, 8, 1'b0);
      bpMode = 1'b0;
      runBurst(7'h40, 8'd0, 0, 1'b1);
      runBurst(7'h05, 8'd128, 128, 1'b1);
      runBurst(7'h00, 8'd200, 128, 1'b1);

      // Reset after the 5th word of a 16-word burst
      clearMon();
      @(posedge clk); #1;
      intf.req_valid = 1'b1; intf.req_addr = 7'h20; intf.req_len = 8'd16;
      @(posedge clk); #1;
      intf.req_valid = 1'b0;
      w = 0;
      while (rxData.size() < 5 && w < 100) begin
         @(negedge clk); #1;
         w++;
      end
      check("midWords", 128'(rxData.size()), 128'(5));
      #1 rstN = 1'b0;
      #1 checkReset("midReset");
      repeat (3) @(negedge clk);
      #1 checkReset("midHeld");
      check("midNoDone", 128'(doneCyc.size()), 128'(0));
      @(negedge clk) rstN = 1'b1;
      runBurst(7'h00, 8'd2, 2, 1'b1);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
